// File: rtl/mixer_n_gain.sv
// mixer_n_gain: mixes NUM_CH signed channels with per-channel gain and mute
// using one shared multiply-accumulate, producing one sample per lrclk frame.
module mixer_n_gain #(
  parameter int BITSIZE  = 24,
  parameter int NUM_CH   = 4,
  parameter int GAINSIZE = 8
) (
  input  logic                       bclk,
  input  logic                       reset_n,
  input  logic                       lrclk,
  input  logic [NUM_CH*BITSIZE-1:0]  in_flat,
  input  logic [NUM_CH*GAINSIZE-1:0] gain_flat,
  input  logic [NUM_CH-1:0]          mute,
  input  logic                       avg_mode,
  output logic [BITSIZE-1:0]         out,
  output logic                       valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int CW   = $clog2(NUM_CH);
  localparam int PW   = BITSIZE + GAINSIZE + 1;
  localparam int ACCW = BITSIZE + GAINSIZE + CW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CH - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                     state_q, state_d;
  logic                       lr_q, lr_d;
  logic [CW-1:0]              idx_q, idx_d;
  logic signed [ACCW-1:0]     acc_q, acc_d;
  logic [NUM_CH*BITSIZE-1:0]  in_snap_q, in_snap_d;
  logic [NUM_CH*GAINSIZE-1:0] gain_snap_q, gain_snap_d;
  logic [NUM_CH-1:0]          mute_snap_q, mute_snap_d;
  logic                       avg_snap_q, avg_snap_d;
  logic [BITSIZE-1:0]         out_q, out_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;

  logic                       lr_rise;
  logic [BITSIZE-1:0]         sample_sel;
  logic [GAINSIZE-1:0]        gain_sel;
  logic                       mute_sel;
  logic [PW-1:0]              prod;
  logic signed [ACCW-1:0]     contrib;
  logic signed [ACCW-1:0]     shifted;
  logic [BITSIZE-1:0]         sat_val;

  assign lr_rise = lrclk & ~lr_q;

  // Channel select and MAC datapath; gain is zero-extended so the product is signed x unsigned.
  always_comb begin
    sample_sel = '0;
    gain_sel   = '0;
    mute_sel   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == CW'(i)) begin
        sample_sel = in_snap_q[i*BITSIZE +: BITSIZE];
        gain_sel   = gain_snap_q[i*GAINSIZE +: GAINSIZE];
        mute_sel   = mute_snap_q[i];
      end
    end
    prod    = {{(GAINSIZE+1){sample_sel[BITSIZE-1]}}, sample_sel} *
              {{(BITSIZE+1){1'b0}}, gain_sel};
    contrib = mute_sel ? '0 : {{CW{prod[PW-1]}}, prod};
  end

  always_comb begin
    shifted = avg_snap_q ? (acc_q >>> (GAINSIZE - 1 + CW)) : (acc_q >>> (GAINSIZE - 1));
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[BITSIZE-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[BITSIZE-1:0];
    end else begin
      sat_val = shifted[BITSIZE-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    lr_d        = lrclk;
    idx_d       = idx_q;
    acc_d       = acc_q;
    in_snap_d   = in_snap_q;
    gain_snap_d = gain_snap_q;
    mute_snap_d = mute_snap_q;
    avg_snap_d  = avg_snap_q;
    out_d       = out_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;

    // A frame edge that arrives outside IDLE (including the DONE cycle) is dropped.
    if (lr_rise && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (lr_rise) begin
          in_snap_d   = in_flat;
          gain_snap_d = gain_flat;
          mute_snap_d = mute;
          avg_snap_d  = avg_mode;
          acc_d       = '0;
          idx_d       = '0;
          busy_d      = 1'b1;
          state_d     = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + contrib;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_d   = sat_val;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lr_q        <= 1'b0;
      idx_q       <= '0;
      acc_q       <= '0;
      in_snap_q   <= '0;
      gain_snap_q <= '0;
      mute_snap_q <= '0;
      avg_snap_q  <= 1'b0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lr_q        <= lr_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      in_snap_q   <= in_snap_d;
      gain_snap_q <= gain_snap_d;
      mute_snap_q <= mute_snap_d;
      avg_snap_q  <= avg_snap_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out     = out_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule
